// File: rtl/cpc_romsel_ctrl.sv
// rtl/cpc_romsel_ctrl.sv - CPC upper ROM select decoder and 74245 bus-drive controller
// Optional LOWER_ROM_EN adds lrom_sel and serves lower ROM reads from bank NUM_SLOTS.
module cpc_romsel_ctrl #(
  parameter int NUM_SLOTS  = 16,
  parameter int SLOT_BASE  = 1,
  parameter int ROMSEL_RST = 0,
  parameter int HOLD_CYC   = 1,
  parameter int MAX_DRIVE  = 8,
  localparam int BANK_W    = $clog2(NUM_SLOTS + 1)
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic              A15,
  input  logic              A14,
  input  logic              A13,
  input  logic [7:0]        D,
  input  logic              IOREQ_B,
  input  logic              WR_B,
  input  logic              ROMEN_B,
`ifdef LOWER_ROM_EN
  input  logic              lrom_sel,
`endif
  output logic              ROMDIS,
  output logic              bufoe_b,
  output logic [BANK_W-1:0] rom_bank,
  output logic              drive_err
);

  localparam int DRV_W = (MAX_DRIVE > 1) ? $clog2(MAX_DRIVE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               ioreq_s, wr_s, a13_s, romen_s;
  logic               wr_hit, wr_seen, armed;
  logic [7:0]         romsel;
  logic               slot_hit;
  logic               upper_go, lower_go;
  logic               block_q, block_d, err_d;
  logic [DRV_W-1:0]   drv_cnt, drv_cnt_d;
  logic [1:0]         hold_cnt, hold_cnt_d;
  logic [BANK_W-1:0]  bank_d;

  function automatic logic in_range(input logic [7:0] v);
    return (9'(v) >= 9'(SLOT_BASE)) && (9'(v) <= 9'(SLOT_BASE + NUM_SLOTS - 1));
  endfunction

  assign wr_hit = !ioreq_s && !wr_s && !a13_s;

  // Strobe sampling and ROM select write decoder; one latch per IOREQ strobe.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ioreq_s  <= 1'b1;
      wr_s     <= 1'b1;
      a13_s    <= 1'b1;
      romen_s  <= 1'b1;
      wr_seen  <= 1'b0;
      armed    <= 1'b1;
      romsel   <= 8'(ROMSEL_RST);
      slot_hit <= in_range(8'(ROMSEL_RST));
    end else begin
      ioreq_s  <= IOREQ_B;
      wr_s     <= WR_B;
      a13_s    <= A13;
      romen_s  <= ROMEN_B;
      wr_seen  <= wr_hit;
      slot_hit <= in_range(romsel);
      if (ioreq_s) begin
        armed <= 1'b1;
      end else if (wr_hit && wr_seen && armed) begin
        romsel <= D;
        armed  <= 1'b0;
      end
    end
  end

  assign upper_go = !romen_s && A15 && A14 && slot_hit;

`ifdef LOWER_ROM_EN
  assign lower_go = lrom_sel && !romen_s && !A15 && !A14;
  assign ROMDIS   = (slot_hit && A14) || (lrom_sel && !A15 && !A14);
`else
  assign lower_go = 1'b0;
  assign ROMDIS   = slot_hit && A14;
`endif

  assign bufoe_b = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    drv_cnt_d  = drv_cnt;
    hold_cnt_d = hold_cnt;
    block_d    = block_q;
    err_d      = drive_err;
    bank_d     = rom_bank;
    if (romen_s) begin
      block_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        // Bank only tracks romsel while idle so an access never sees it change.
        bank_d = in_range(romsel) ? BANK_W'(romsel - 8'(SLOT_BASE)) : '0;
        if (!block_q && (upper_go || lower_go)) begin
          state_d   = DRIVE;
          drv_cnt_d = '0;
`ifdef LOWER_ROM_EN
          if (lower_go) begin
            bank_d = BANK_W'(NUM_SLOTS);
          end
`endif
        end
      end
      DRIVE: begin
        if (romen_s) begin
          state_d    = (HOLD_CYC == 0) ? IDLE : HOLD;
          hold_cnt_d = '0;
        end else if (drv_cnt == DRV_W'(MAX_DRIVE - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          block_d = 1'b1;
        end else begin
          drv_cnt_d = drv_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == 2'(HOLD_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q   <= IDLE;
      drv_cnt   <= '0;
      hold_cnt  <= '0;
      block_q   <= 1'b0;
      drive_err <= 1'b0;
      rom_bank  <= '0;
    end else begin
      state_q   <= state_d;
      drv_cnt   <= drv_cnt_d;
      hold_cnt  <= hold_cnt_d;
      block_q   <= block_d;
      drive_err <= err_d;
      rom_bank  <= bank_d;
    end
  end

endmodule

// File: tb/tb_cpc_romsel_ctrl.sv
// tb/tb_cpc_romsel_ctrl.sv - directed bench for cpc_romsel_ctrl (default parameters)
module tb_cpc_romsel_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_B, A15, A14, A13, IOREQ_B, WR_B, ROMEN_B, lrom_sel;
  logic [7:0] D;
  logic       ROMDIS, bufoe_b, drive_err;
  logic [4:0] rom_bank;

  int n_cmp = 0;
  int n_bad = 0;

  cpc_romsel_ctrl dut (
    .CLK       (CLK),
    .RESET_B   (RESET_B),
    .A15       (A15),
    .A14       (A14),
    .A13       (A13),
    .D         (D),
    .IOREQ_B   (IOREQ_B),
    .WR_B      (WR_B),
    .ROMEN_B   (ROMEN_B),
`ifdef LOWER_ROM_EN
    .lrom_sel  (lrom_sel),
`endif
    .ROMDIS    (ROMDIS),
    .bufoe_b   (bufoe_b),
    .rom_bank  (rom_bank),
    .drive_err (drive_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic io_write(input logic [7:0] d);
    IOREQ_B = 1'b0; WR_B = 1'b0; A13 = 1'b0; D = d;
    cyc(3);
    IOREQ_B = 1'b1; WR_B = 1'b1; A13 = 1'b1;
    cyc(2);
  endtask

  initial begin
    RESET_B = 1'b0; A15 = 1'b1; A14 = 1'b1; A13 = 1'b1; D = 8'h00;
    IOREQ_B = 1'b1; WR_B = 1'b1; ROMEN_B = 1'b1; lrom_sel = 1'b0;
    cyc(2);
    check_eq("rst_bufoe", bufoe_b, 1);
    check_eq("rst_bank", rom_bank, 0);
    check_eq("rst_err", drive_err, 0);
    check_eq("rst_romdis", ROMDIS, 0);
    RESET_B = 1'b1;
    cyc(1);

    // IO write 0x05; D changes after the latch point and must be ignored
    IOREQ_B = 1'b0; WR_B = 1'b0; A13 = 1'b0; D = 8'h05;
    cyc(2);
    check_eq("pre_latch_romdis", ROMDIS, 0);
    cyc(1);
    D = 8'h09;
    check_eq("slot_hit_lag", ROMDIS, 0);
    cyc(1);
    check_eq("sel5_bank", rom_bank, 4);
    check_eq("sel5_romdis", ROMDIS, 1);
    cyc(1);
    IOREQ_B = 1'b1; WR_B = 1'b1; A13 = 1'b1;
    cyc(2);
    check_eq("one_latch_bank", rom_bank, 4);
    A14 = 1'b0; #1;
    check_eq("romdis_a14_low", ROMDIS, 0);
    A14 = 1'b1; #1;

    // Upper ROM read: 3 cycles of ROMEN_B low
    ROMEN_B = 1'b0;
    cyc(1);
    check_eq("rd_sample", bufoe_b, 1);
    cyc(1);
    check_eq("rd_drive0", bufoe_b, 0);
    cyc(1);
    ROMEN_B = 1'b1;
    check_eq("rd_drive1", bufoe_b, 0);
    cyc(1);
    check_eq("rd_drive2", bufoe_b, 0);
    cyc(1);
    check_eq("rd_hold", bufoe_b, 0);
    cyc(1);
    check_eq("rd_idle", bufoe_b, 1);
    check_eq("rd_no_err", drive_err, 0);

    // romsel write 0x07 during an access: bank frozen until idle
    ROMEN_B = 1'b0;
    cyc(2);
    check_eq("wr_drv_bufoe", bufoe_b, 0);
    IOREQ_B = 1'b0; WR_B = 1'b0; A13 = 1'b0; D = 8'h07;
    cyc(3);
    IOREQ_B = 1'b1; WR_B = 1'b1; A13 = 1'b1;
    cyc(1);
    check_eq("bank_frozen_drv", rom_bank, 4);
    ROMEN_B = 1'b1;
    cyc(2);
    check_eq("bank_frozen_hold", rom_bank, 4);
    check_eq("hold_bufoe", bufoe_b, 0);
    cyc(1);
    check_eq("back_idle", bufoe_b, 1);
    cyc(1);
    check_eq("bank_new", rom_bank, 6);

    // Watchdog: ROMEN_B low for 12 cycles
    ROMEN_B = 1'b0;
    cyc(2);
    check_eq("wd_first", bufoe_b, 0);
    cyc(7);
    check_eq("wd_last", bufoe_b, 0);
    check_eq("wd_err_pre", drive_err, 0);
    cyc(1);
    check_eq("wd_abort", bufoe_b, 1);
    check_eq("wd_err", drive_err, 1);
    cyc(2);
    check_eq("wd_block", bufoe_b, 1);
    ROMEN_B = 1'b1;
    cyc(3);
    check_eq("wd_err_sticky", drive_err, 1);
    ROMEN_B = 1'b0;
    cyc(2);
    check_eq("redrive", bufoe_b, 0);
    ROMEN_B = 1'b1;
    cyc(4);
    check_eq("redrive_end", bufoe_b, 1);

    // Slot range boundaries
    io_write(8'h10);
    check_eq("last_slot_bank", rom_bank, 15);
    check_eq("last_slot_romdis", ROMDIS, 1);
    io_write(8'h11);
    check_eq("above_bank", rom_bank, 0);
    check_eq("above_romdis", ROMDIS, 0);
    io_write(8'h00);
    check_eq("sel0_romdis", ROMDIS, 0);
    check_eq("sel0_bank", rom_bank, 0);
    ROMEN_B = 1'b0;
    cyc(3);
    check_eq("sel0_no_drive", bufoe_b, 1);
    ROMEN_B = 1'b1;
    cyc(2);

    // Asynchronous reset during a drive
    io_write(8'h05);
    ROMEN_B = 1'b0;
    cyc(2);
    check_eq("pre_rst_drive", bufoe_b, 0);
    #1 RESET_B = 1'b0;
    #1;
    check_eq("async_rst_bufoe", bufoe_b, 1);
    check_eq("async_rst_bank", rom_bank, 0);
    check_eq("async_rst_err", drive_err, 0);
    check_eq("async_rst_romdis", ROMDIS, 0);
    ROMEN_B = 1'b1;
    cyc(1);
    RESET_B = 1'b1;
    cyc(1);

`ifdef LOWER_ROM_EN
    lrom_sel = 1'b1; A15 = 1'b0; A14 = 1'b0; #1;
    check_eq("lrom_romdis", ROMDIS, 1);
    ROMEN_B = 1'b0;
    cyc(2);
    check_eq("lrom_bufoe", bufoe_b, 0);
    check_eq("lrom_bank", rom_bank, 16);
    ROMEN_B = 1'b1;
    cyc(4);
    check_eq("lrom_end", bufoe_b, 1);
    lrom_sel = 1'b0; A15 = 1'b1; A14 = 1'b1;
    cyc(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpc_romsel_ctrl.md
CPC_ROMSEL_CTRL -- requirements
Module: cpc_romsel_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 16: number of emulated upper ROM slots, range 1..32.
REQ-002 SHALL have parameter SLOT_BASE, default 1: first ROM select number served; SLOT_BASE+NUM_SLOTS SHALL be at most 256.
REQ-003 SHALL have parameter ROMSEL_RST, default 0: ROM select register value at reset.
REQ-004 SHALL have parameter HOLD_CYC, default 1: number of bus-drive hold cycles after ROMEN_B deasserts, range 0..3.
REQ-005 SHALL have parameter MAX_DRIVE, default 8: watchdog limit in CLK cycles for one drive period.
REQ-006 SHALL have derived localparam BANK_W = clog2(NUM_SLOTS+1).
REQ-007 CLK input 1: single clock, CPC bus clock; all logic is rising-edge triggered.
REQ-008 RESET_B input 1: asynchronous active-low reset.
REQ-009 A15, A14, A13 inputs 1 each: CPC address bits.
REQ-010 D input 8: CPC data bus as seen for IO writes.
REQ-011 IOREQ_B, WR_B, ROMEN_B inputs 1 each: CPC strobes, active low.
REQ-012 ROMDIS output 1: disables the internal CPC ROM.
REQ-013 bufoe_b output 1: active-low output enable for the 74245 data buffer.
REQ-014 rom_bank output BANK_W: bank index presented to the ROM store.
REQ-015 drive_err output 1: sticky watchdog error flag.

Function
REQ-016 SHALL register IOREQ_B, WR_B, A13 and ROMEN_B once on CLK; all decoding SHALL use these registered values (sampled signals denoted _s).
REQ-017 IO write SHALL be decoded when IOREQ_B_s=0, WR_B_s=0 and A13_s=0 for 2 consecutive cycles; D SHALL be latched into romsel[7:0] on the second cycle.
REQ-018 Exactly one latch SHALL occur per strobe; the decoder SHALL rearm only after IOREQ_B_s returns to 1.
REQ-019 slot_hit SHALL be registered one cycle after romsel changes, set when SLOT_BASE <= romsel <= SLOT_BASE+NUM_SLOTS-1.
REQ-020 ROMDIS SHALL equal slot_hit AND A14, combinational from the live A14 pin, with no other term.
REQ-021 rom_bank SHALL equal romsel-SLOT_BASE when slot_hit=1, otherwise 0; rom_bank SHALL be registered.
REQ-022 The FSM SHALL have states IDLE, DRIVE, HOLD; bufoe_b SHALL be 0 in DRIVE and HOLD, and 1 in IDLE.
REQ-023 IDLE->DRIVE SHALL occur when ROMEN_B_s=0, A15=1, A14=1 and slot_hit=1.
REQ-024 DRIVE->HOLD SHALL occur when ROMEN_B_s=1; if HOLD_CYC=0 the transition SHALL go directly DRIVE->IDLE.
REQ-025 HOLD SHALL last HOLD_CYC cycles and then return to IDLE; ROMEN_B_s=0 during HOLD SHALL NOT re-enter DRIVE until IDLE has been reached for 1 cycle.
REQ-026 Watchdog: a counter SHALL run in DRIVE; on reaching MAX_DRIVE the FSM SHALL go to IDLE, drive_err SHALL be set, and DRIVE SHALL not be re-entered until ROMEN_B_s=1 has been seen.
REQ-027 A romsel change during DRIVE/HOLD SHALL NOT alter the state or rom_bank until the FSM returns to IDLE, so that no mid-access glitch occurs.
REQ-028 A romsel value outside the slot range SHALL clear slot_hit; ROMDIS SHALL then be 0 and no drive SHALL occur.

Reset
REQ-029 On RESET_B=0, immediately and asynchronously: romsel=ROMSEL_RST, slot_hit from ROMSEL_RST, FSM=IDLE, bufoe_b=1, rom_bank=0, drive_err=0, counters 0, decoder armed.
REQ-030 Reset asserted mid-DRIVE SHALL release the buffer within the reset propagation delay, with no clock required.

Configuration
REQ-031 Macro LOWER_ROM_EN defined: SHALL add input lrom_sel (1 bit). When lrom_sel=1, ROMEN_B_s=0, A15=0 and A14=0, the FSM SHALL enter DRIVE with rom_bank=NUM_SLOTS, and ROMDIS SHALL also assert while A15=0 and A14=0.
REQ-032 Macro LOWER_ROM_EN undefined: the lrom_sel port SHALL be absent, lower-ROM accesses SHALL be ignored, and bank index NUM_SLOTS SHALL be unused.

Verification
REQ-033 Reset; IO write D=0x05 to A13=0 -> romsel=5 and slot_hit=1 two cycles later; rom_bank=4; ROMDIS=1 while A14=1.
REQ-034 romsel=5, ROMEN_B low 3 cycles at A15=A14=1 -> bufoe_b low 1 cycle after the ROMEN_B_s fall, held for the access plus 1 HOLD cycle, then high.
REQ-035 IO write D=0x00 -> slot_hit=0; ROMDIS=0; an upper ROM read leaves bufoe_b=1.
REQ-036 ROMEN_B held low 12 cycles with MAX_DRIVE=8 -> bufoe_b high after 8 DRIVE cycles, drive_err=1 until reset.
REQ-037 IO write D=0x07 during DRIVE -> rom_bank stays 4 until IDLE, then becomes 6.
REQ-038 RESET_B low mid-DRIVE -> bufoe_b=1 asynchronously, romsel=ROMSEL_RST; with LOWER_ROM_EN, lrom_sel=1 and a lower read -> rom_bank=NUM_SLOTS and bufoe_b low.
